mag_cmp_seq: RTL

// - Parametrised multi-cycle magnitude comparator; successor to the 16-bit ripple compare.
// - Compares A and B MSB-first, DIGIT bits per clock, and stops early at the first differing digit.
// - Supports unsigned and two's-complement operands; start/busy/done handshake.
// - Used where wide compares (scores, paddle/ball positions) must not sit in one combinational path.

---
 rtl/mag_cmp_pkg.sv | 23 ++
 rtl/cmp_digit.sv | 17 +
 rtl/mag_cmp_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mag_cmp_pkg.sv
// Shared types for the sequential magnitude comparator.
//   state_t   : controller states
//   cmp_res_t : one-hot result flags {gt, eq, lt}
//   idx_width : width of the digit index counter (never below 1 bit)
package mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic gt;
        logic eq;
        logic lt;
    } cmp_res_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational unsigned compare of one digit pair.
//   a_i, b_i : digit operands (DIGIT bits)
//   gt_o     : a_i > b_i
//   lt_o     : a_i < b_i   (equal when neither is set)
module cmp_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a_i,
    input  logic [DIGIT-1:0] b_i,
    output logic             gt_o,
    output logic             lt_o
);

    assign gt_o = (a_i > b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/mag_cmp_seq.sv
// Multi-cycle magnitude comparator. Walks A and B MSB-first, DIGIT bits per
// clock, and stops at the first differing digit.
//   clk, rst         : clock, synchronous active-high reset
//   start            : request a compare (taken only in IDLE)
//   signed_i         : 1 = two's-complement operands, sampled with start
//   A, B             : operands, sampled on the accepting edge
//   busy             : high from the cycle after acceptance through done
//   done             : one-cycle pulse, flags valid from this cycle
//   AgtB, AeqB, AltB : result flags, held until the next done
//
// state | meaning
// IDLE  | waiting for start; flags hold the last result
// CMP   | comparing digit idx of the captured operands
// DONE  | result latched, done pulse; start ignored
module mag_cmp_seq
    import mag_cmp_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             AgtB,
    output logic             AeqB,
    output logic             AltB
);

    localparam int N  = WIDTH / DIGIT;
    localparam int IW = idx_width(N);

    if (DIGIT < 1) begin : g_bad_digit
        $error("mag_cmp_seq: DIGIT must be >= 1");
    end
    if ((DIGIT >= 1) && ((WIDTH % DIGIT) != 0)) begin : g_bad_split
        $error("mag_cmp_seq: DIGIT must divide WIDTH");
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("mag_cmp_seq: WIDTH must be >= 2");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IW-1:0]    idx_q, idx_d;
    cmp_res_t         res_q, res_d;

    logic [WIDTH-1:0] a_sh, b_sh;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic             dig_gt, dig_lt;
    logic [WIDTH-1:0] bias;

    // Flipping the sign bit of both operands maps two's-complement order onto
    // unsigned order, so the datapath only ever does unsigned compares.
    assign bias = {signed_i, {(WIDTH-1){1'b0}}};

    assign a_sh  = a_q >> (idx_q * DIGIT);
    assign b_sh  = b_q >> (idx_q * DIGIT);
    assign a_dig = a_sh[DIGIT-1:0];
    assign b_dig = b_sh[DIGIT-1:0];

    cmp_digit #(.DIGIT(DIGIT)) u_cmp_digit (
        .a_i  (a_dig),
        .b_i  (b_dig),
        .gt_o (dig_gt),
        .lt_o (dig_lt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        res_d   = res_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A ^ bias;
                    b_d     = B ^ bias;
                    idx_d   = IW'(N - 1);
                    state_d = CMP;
                end
            end
            CMP: begin
                if (dig_gt || dig_lt) begin
                    res_d   = '{gt: dig_gt, eq: 1'b0, lt: dig_lt};
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    res_d   = '{gt: 1'b0, eq: 1'b1, lt: 1'b0};
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        AgtB = res_q.gt;
        AeqB = res_q.eq;
        AltB = res_q.lt;
    end

endmodule
